psum_accum: RTL and testbench

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/psum_pkg.sv | 24 ++
 rtl/psum_lane_reduce.sv | 25 ++
 rtl/psum_accum.sv | 179 +++++++++++++++++
 tb/tb_psum_accum.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// precision-mode encodings of the incoming product word and the FSM state
// encoding. Imported by psum_lane_reduce and psum_accum.
package psum_pkg;

    localparam int DEF_ACC_W = 32;
    localparam int DEF_LEN_W = 8;
    localparam int PROD_W    = 16;

    // Mode 2'b11 is reserved and behaves exactly like MODE_8X8.
    typedef enum logic [1:0] {
        MODE_8X8  = 2'b00,
        MODE_4X4  = 2'b01,
        MODE_2X2  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_OUT  = 2'b10
    } state_e;

endpackage

// File: rtl/psum_lane_reduce.sv
// Lane reduction of one packed product word to a single unsigned sum.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the result with its own handshake.
// Ports: in_p  - 16-bit packed product word
//        mode  - precision mode (8x8 / 4x4 / 2x2, reserved treated as 8x8)
//        sum   - 16-bit lane sum (cannot overflow: max is 16'hFFFF in 8x8 mode)
module psum_lane_reduce
    import psum_pkg::*;
(
    input  logic [PROD_W-1:0] in_p,
    input  logic [1:0]        mode,
    output logic [PROD_W-1:0] sum
);

    always_comb begin
        sum = in_p;
        case (mode_e'(mode))
            MODE_4X4: sum = PROD_W'(in_p[15:8]) + PROD_W'(in_p[7:0]);
            MODE_2X2: sum = PROD_W'(in_p[15:12]) + PROD_W'(in_p[11:8])
                          + PROD_W'(in_p[7:4])   + PROD_W'(in_p[3:0]);
            default:  sum = in_p;
        endcase
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums len lane-reduced product beats into one result.
// Latency: result valid the cycle after the last beat; one bubble per group.
// Backpressure: in_ready drops while a result waits; result held until out_ready.
//
// Ports: clk/nrst (async active-low reset), mode/len (sampled on a group's
// first beat only), in_valid/in_ready/in_p (beat input), out_valid/out_ready/
// out_sum/out_ovf (result output; sum and valid are zero outside the result).
// Build option: define PSUM_SAT_EN to clamp the accumulator at all-ones on
// overflow; otherwise it wraps. out_ovf flags the overflow either way.
module psum_accum
    import psum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        mode,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int SUM_W = ACC_W + 1;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic               in_rdy_q, in_rdy_d;
    logic               out_vld_q, out_vld_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic [1:0]         mode_sel;
    logic [PROD_W-1:0]  lane_sum;
    logic [ACC_W-1:0]   lane_ext;
    logic [SUM_W-1:0]   add_full;
    logic               carry;
    logic [ACC_W-1:0]   acc_add;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   cnt_inc;

    assign accept   = in_valid && in_rdy_q;
    // The first beat of a group is reduced with the live mode; later beats
    // use the mode latched with that first beat.
    assign mode_sel = (state_q == ST_IDLE) ? mode : mode_q;
    assign len_eff  = (len == '0) ? LEN_W'(1) : len;
    assign cnt_inc  = cnt_q + LEN_W'(1);

    psum_lane_reduce u_lane (
        .in_p (in_p),
        .mode (mode_sel),
        .sum  (lane_sum)
    );

    assign lane_ext = ACC_W'(lane_sum);
    assign add_full = SUM_W'(acc_q) + SUM_W'(lane_sum);
    assign carry    = add_full[ACC_W];

    always_comb begin
`ifdef PSUM_SAT_EN
        // Once clamped, any further non-zero add carries again, so the
        // accumulator stays pinned at all-ones for the rest of the group.
        acc_add = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        acc_add = add_full[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        in_rdy_d  = in_rdy_q;
        out_vld_d = out_vld_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            ST_IDLE: begin
                in_rdy_d = 1'b1;
                if (accept) begin
                    mode_d = mode;
                    len_d  = len_eff;
                    acc_d  = lane_ext;
                    cnt_d  = LEN_W'(1);
                    ovf_d  = 1'b0;
                    if (len_eff == LEN_W'(1)) begin
                        state_d   = ST_OUT;
                        in_rdy_d  = 1'b0;
                        out_vld_d = 1'b1;
                        out_sum_d = lane_ext;
                        out_ovf_d = 1'b0;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                in_rdy_d = 1'b1;
                if (accept) begin
                    acc_d = acc_add;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (cnt_inc == len_q) begin
                        state_d   = ST_OUT;
                        in_rdy_d  = 1'b0;
                        out_vld_d = 1'b1;
                        out_sum_d = acc_add;
                        out_ovf_d = ovf_q | carry;
                    end
                end
            end
            ST_OUT: begin
                in_rdy_d  = 1'b0;
                out_vld_d = 1'b1;
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    in_rdy_d  = 1'b1;
                    out_vld_d = 1'b0;
                    out_sum_d = '0;
                    out_ovf_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                in_rdy_d  = 1'b1;
                out_vld_d = 1'b0;
                out_sum_d = '0;
                out_ovf_d = 1'b0;
            end
        endcase
    end

    // in_ready is registered, so it reads 0 during reset and for the first
    // cycle after release; the upstream simply waits one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            ovf_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [LW-1:0] len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_p = 16'd0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_sum;
    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_sum16;

    psum_accum #(.ACC_W(32), .LEN_W(LW)) dut (
        .clk(clk), .nrst(nrst), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    psum_accum #(.ACC_W(16), .LEN_W(LW)) dut16 (
        .clk(clk), .nrst(nrst), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_p(in_p),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_sum(out_sum16), .out_ovf(out_ovf16)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] beatq[$];

`ifdef PSUM_SAT_EN
    localparam logic [63:0] OVF16_A = 64'hFFFF;
    localparam logic [63:0] OVF16_B = 64'hFFFF;
`else
    localparam logic [63:0] OVF16_A = 64'h0001;
    localparam logic [63:0] OVF16_B = 64'h0005;
`endif

    typedef struct {
        string              nm;
        int                 md;
        int                 ln;
        int                 nb;
        logic [3:0][15:0]   p;
        logic [63:0]        s32;
        logic               o32;
        logic [63:0]        s16;
        logic               o16;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference lane sum, straight from the mode definitions.
    function automatic longint lane_of(input int md, input logic [15:0] p);
        longint s;
        s = 0;
        case (md)
            1: s = longint'(p[15:8]) + longint'(p[7:0]);
            2: for (int k = 0; k < 4; k++) s += longint'((p >> (4 * k)) & 16'h000F);
            default: s = longint'(p);
        endcase
        return s;
    endfunction

    // Group result for a w-bit accumulator over the beats in beatq.
    task automatic model(input int md, input int w, output logic [63:0] s, output logic o);
        longint lim, acc, t;
        lim = longint'(1) << w;
        acc = lane_of(md, beatq[0]);
        o = 1'b0;
        for (int i = 1; i < beatq.size(); i++) begin
            t = acc + lane_of(md, beatq[i]);
            if (t >= lim) begin
                o = 1'b1;
`ifdef PSUM_SAT_EN
                acc = lim - 1;
`else
                acc = t - lim;
`endif
            end else begin
                acc = t;
            end
        end
        s = 64'(acc);
    endtask

    task automatic send_beat(input logic [15:0] p, input string nm);
        bit ok;
        in_valid = 1'b1;
        in_p = p;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_group(input int md, input int ln, input int stall, input int gap,
                             input string nm, input logic [63:0] e32, input logic eo32,
                             input logic [63:0] e16, input logic eo16);
        int n;
        n = beatq.size();
        out_ready = (stall == 0);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                mode = 2'(md);
                len  = LW'(ln);
            end else begin
                // Scramble mode/len mid-group; the DUT must ignore them.
                mode = (md == 2) ? 2'd0 : 2'd2;
                len  = LW'(ln + 3);
            end
            send_beat(beatq[i], nm);
            if (gap > 0 && i < n - 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap)) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_sum"}, 64'(out_sum), e32);
        chk({nm, "_ovf"}, 64'(out_ovf), 64'(eo32));
        chk({nm, "_valid16"}, 64'(out_valid16), 64'd1);
        chk({nm, "_sum16"}, 64'(out_sum16), e16);
        chk({nm, "_ovf16"}, 64'(out_ovf16), 64'(eo16));
        chk({nm, "_ready_low"}, 64'(in_ready), 64'd0);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1;
            in_p = 16'($urandom);
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_hold_sum"}, 64'(out_sum), e32);
            chk({nm, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_done_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_done_sum"}, 64'(out_sum), 64'd0);
    endtask

    task automatic set_vec(input int idx, input string nm, input int md, input int ln, input int nb,
                           input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                           input logic [15:0] p3, input logic [63:0] s32, input logic o32,
                           input logic [63:0] s16, input logic o16);
        tbl[idx].nm = nm;   tbl[idx].md = md;   tbl[idx].ln = ln;  tbl[idx].nb = nb;
        tbl[idx].p[0] = p0; tbl[idx].p[1] = p1; tbl[idx].p[2] = p2; tbl[idx].p[3] = p3;
        tbl[idx].s32 = s32; tbl[idx].o32 = o32; tbl[idx].s16 = s16; tbl[idx].o16 = o16;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] s32, s16;
        logic o32, o16;
        int md, ln, n;

        set_vec(0, "m0_len3",  0, 3, 3, 16'd15, 16'd45, 16'd100, 16'd0, 64'd160, 1'b0, 64'd160, 1'b0);
        set_vec(1, "m1_len1",  1, 1, 1, 16'h0323, 16'd0, 16'd0, 16'd0, 64'd38, 1'b0, 64'd38, 1'b0);
        set_vec(2, "m2_len2",  2, 2, 2, 16'h1234, 16'hFFFF, 16'd0, 16'd0, 64'd70, 1'b0, 64'd70, 1'b0);
        set_vec(3, "ovf16",    0, 2, 2, 16'hFFFF, 16'h0002, 16'd0, 16'd0, 64'h10001, 1'b0, OVF16_A, 1'b1);
        set_vec(4, "len0",     0, 0, 1, 16'd9, 16'd0, 16'd0, 16'd0, 64'd9, 1'b0, 64'd9, 1'b0);
        set_vec(5, "mode_chg", 0, 2, 2, 16'h0011, 16'h0022, 16'd0, 16'd0, 64'h33, 1'b0, 64'h33, 1'b0);
        set_vec(6, "rsvd",     3, 1, 1, 16'h1234, 16'd0, 16'd0, 16'd0, 64'h1234, 1'b0, 64'h1234, 1'b0);
        set_vec(7, "m1_len4",  1, 4, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'd2040, 1'b0, 64'd2040, 1'b0);
        set_vec(8, "sticky16", 0, 3, 3, 16'hFFFF, 16'h0005, 16'h0001, 16'd0, 64'h10005, 1'b0, OVF16_B, 1'b1);

        // Reset state
        #2 nrst = 1'b0;
        #10;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            beatq.delete();
            for (int j = 0; j < tbl[v].nb; j++) beatq.push_back(tbl[v].p[j]);
            run_group(tbl[v].md, tbl[v].ln, 0, 0, tbl[v].nm,
                      tbl[v].s32, tbl[v].o32, tbl[v].s16, tbl[v].o16);
        end

        // Result stalled 5 cycles with beats offered meanwhile
        beatq.delete();
        beatq.push_back(16'd15); beatq.push_back(16'd45); beatq.push_back(16'd100);
        run_group(0, 3, 5, 0, "stall", 64'd160, 1'b0, 64'd160, 1'b0);
        // Beats offered during the stall must not leak into the next group
        beatq.delete();
        beatq.push_back(16'd21);
        run_group(0, 1, 0, 0, "post_stall", 64'd21, 1'b0, 64'd21, 1'b0);

        // Reset in the middle of a group
        mode = 2'd0;
        len = LW'(4);
        send_beat(16'd3, "midrst_b0");
        send_beat(16'd3, "midrst_b1");
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(out_sum), 64'd0);
        chk("midrst_ovf", 64'(out_ovf), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        beatq.delete();
        beatq.push_back(16'd7);
        run_group(0, 1, 0, 0, "after_midrst", 64'd7, 1'b0, 64'd7, 1'b0);

        // Randomized groups against the reference model
        for (int g = 0; g < 40; g++) begin
            md = int'($urandom_range(3));
            ln = int'($urandom_range(6));
            n = (ln == 0) ? 1 : ln;
            beatq.delete();
            for (int j = 0; j < n; j++)
                beatq.push_back($urandom_range(1) ? 16'($urandom) : 16'($urandom_range(255)));
            model(md, 32, s32, o32);
            model(md, 16, s16, o16);
            run_group(md, ln, ($urandom_range(3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(2)), "rnd", s32, o32, s16, o16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
